// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS trace capture block: capture state encoding
// and the width of one stored trace entry.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } cap_state_t;

  // One entry holds an ALUresult/WriteDataMem pair.
  function automatic int trace_entry_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/mips_trace_capture_ram.sv
// Trace storage: DEPTH x WIDTH array with one write port and an enabled,
// registered read port. Contents are deliberately not reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mips_trace_capture.sv
// On-chip trace buffer for the single-cycle MIPS core: captures ALUresult /
// WriteDataMem pairs until a value match (plus post window) or a cycle limit.
module mips_trace_capture
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 8,
  parameter int CYCLE_LIMIT = 20,
  parameter int CNT_W       = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          ALUresult,
  input  logic [DATA_W-1:0]          WriteDataMem,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [DATA_W-1:0]          trig_value,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_alu,
  output logic [DATA_W-1:0]          rd_wdm,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     valid_count,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int VW      = AW + 1;
  localparam int ENTRY_W = trace_entry_w(DATA_W);

  cap_state_t          st;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       post_cnt;
  logic                rd_loaded;
  logic                capturing;
  logic                match;
  logic                limit_hit;
  logic                rd_fire;
  logic [AW-1:0]       oldest;
  logic [AW-1:0]       rd_idx;
  logic [ENTRY_W-1:0]  rd_q;

  assign capturing = (st == ST_PRE) || (st == ST_POST);
  assign match     = trig_en && (ALUresult == trig_value);
  assign limit_hit = (cycle_count == CNT_W'(CYCLE_LIMIT - 1));
  assign rd_fire   = (st == ST_DONE) && rd_en && !reset;
  // Once the buffer has wrapped, the oldest sample sits at the write pointer.
  assign oldest    = (valid_count == VW'(DEPTH)) ? wr_ptr : '0;
  assign rd_idx    = oldest + rd_addr;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (CLK),
    .we    (capturing && !reset),
    .waddr (wr_ptr),
    .wdata ({ALUresult, WriteDataMem}),
    .re    (rd_fire),
    .raddr (rd_idx),
    .rdata (rd_q)
  );

  // RAM read register has no reset; rd_loaded makes the read outputs zero until first read.
  assign rd_alu = rd_loaded ? rd_q[ENTRY_W-1:DATA_W] : '0;
  assign rd_wdm = rd_loaded ? rd_q[DATA_W-1:0]       : '0;
  assign state  = st;

  always_ff @(posedge CLK) begin
    if (reset) begin
      st          <= ST_IDLE;
      wr_ptr      <= '0;
      post_cnt    <= '0;
      triggered   <= 1'b0;
      timeout     <= 1'b0;
      valid_count <= '0;
      cycle_count <= '0;
      rd_loaded   <= 1'b0;
    end else begin
      if (rd_fire) begin
        rd_loaded <= 1'b1;
      end
      case (st)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            st          <= ST_PRE;
            triggered   <= 1'b0;
            timeout     <= 1'b0;
            wr_ptr      <= '0;
            valid_count <= '0;
            cycle_count <= '0;
          end
        end
        ST_PRE, ST_POST: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (valid_count != VW'(DEPTH)) begin
            valid_count <= valid_count + 1'b1;
          end
          if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
          if (st == ST_PRE) begin
            // A match on the limit cycle takes priority over the timeout.
            if (match) begin
              triggered <= 1'b1;
              if (POST_TRIG == 0) begin
                st <= ST_DONE;
              end else begin
                post_cnt <= AW'(POST_TRIG);
                st       <= ST_POST;
              end
            end else if (limit_hit) begin
              timeout <= 1'b1;
              st      <= ST_DONE;
            end
          end else begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == AW'(1)) begin
              st <= ST_DONE;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_capture.sv
// Bench for mips_trace_capture: a default build and a POST_TRIG=0 build share
// stimulus and are checked against a sample-log reference model.
module tb_mips_trace_capture;

  localparam int DEPTH = 16;
  localparam int LIMIT = 20;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ALUresult = 32'd0;
  logic [31:0] WriteDataMem = 32'd0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_value = 32'd0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = 4'd0;

  logic [31:0] rd_alu_a, rd_wdm_a, rd_alu_b, rd_wdm_b;
  logic [1:0]  state_a, state_b;
  logic        triggered_a, triggered_b, timeout_a, timeout_b;
  logic [4:0]  valid_a, valid_b;
  logic [15:0] cyc_a, cyc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mips_trace_capture dut_a (
    .CLK(CLK), .reset(reset), .ALUresult(ALUresult), .WriteDataMem(WriteDataMem),
    .arm(arm), .trig_en(trig_en), .trig_value(trig_value), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_alu(rd_alu_a), .rd_wdm(rd_wdm_a), .state(state_a), .triggered(triggered_a),
    .timeout(timeout_a), .valid_count(valid_a), .cycle_count(cyc_a)
  );

  mips_trace_capture #(.POST_TRIG(0)) dut_b (
    .CLK(CLK), .reset(reset), .ALUresult(ALUresult), .WriteDataMem(WriteDataMem),
    .arm(arm), .trig_en(trig_en), .trig_value(trig_value), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_alu(rd_alu_b), .rd_wdm(rd_wdm_b), .state(state_b), .triggered(triggered_b),
    .timeout(timeout_b), .valid_count(valid_b), .cycle_count(cyc_b)
  );

  logic [88:0] obs_a, obs_b;
  assign obs_a = {state_a, triggered_a, timeout_a, valid_a, cyc_a, rd_alu_a, rd_wdm_a};
  assign obs_b = {state_b, triggered_b, timeout_b, valid_b, cyc_b, rd_alu_b, rd_wdm_b};

  // Reference model: per build, the log of samples taken since the last arm.
  int          m_state [2];
  int          m_nwr [2];
  int          m_trig_at [2];
  int          m_cyc [2];
  bit          m_trig [2];
  bit          m_to [2];
  bit          m_known [2];
  logic [31:0] m_ra [2];
  logic [31:0] m_rw [2];
  logic [63:0] m_log [2][64];
  int          m_post [2] = '{8, 0};

  function automatic int m_valid(input int k);
    return (m_nwr[k] < DEPTH) ? m_nwr[k] : DEPTH;
  endfunction

  function automatic logic [88:0] exp_vec(input int k);
    return {2'(m_state[k]), m_trig[k], m_to[k], 5'(m_valid(k)), 16'(m_cyc[k]), m_ra[k], m_rw[k]};
  endfunction

  function automatic logic [88:0] exp_mask(input int k);
    return m_known[k] ? {89{1'b1}} : {{25{1'b1}}, 64'd0};
  endfunction

  task automatic model_step(input int k);
    int v;
    if (reset) begin
      m_state[k] = 0; m_nwr[k] = 0; m_cyc[k] = 0; m_trig[k] = 0; m_to[k] = 0;
      m_ra[k] = 32'd0; m_rw[k] = 32'd0; m_known[k] = 1'b1;
    end else begin
      if (m_state[k] == 3 && rd_en) begin
        v = m_valid(k);
        if (int'(rd_addr) < v) begin
          {m_ra[k], m_rw[k]} = m_log[k][m_nwr[k] - v + int'(rd_addr)];
          m_known[k] = 1'b1;
        end else begin
          m_known[k] = 1'b0;
        end
      end
      case (m_state[k])
        0, 3: begin
          if (arm) begin
            m_state[k] = 1; m_nwr[k] = 0; m_cyc[k] = 0; m_trig[k] = 0; m_to[k] = 0;
          end
        end
        1, 2: begin
          m_log[k][m_nwr[k]] = {ALUresult, WriteDataMem};
          m_nwr[k]++;
          if (m_cyc[k] < 65535) m_cyc[k]++;
          if (m_state[k] == 1) begin
            if (trig_en && ALUresult == trig_value) begin
              m_trig[k] = 1; m_trig_at[k] = m_nwr[k] - 1;
              m_state[k] = (m_post[k] == 0) ? 3 : 2;
            end else if (m_nwr[k] == LIMIT) begin
              m_to[k] = 1; m_state[k] = 3;
            end
          end else if (m_nwr[k] == m_trig_at[k] + 1 + m_post[k]) begin
            m_state[k] = 3;
          end
        end
        default: m_state[k] = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
        miscompares++;
        $display("FAIL reset_model dut%0d: got %h expected %h", d, (d == 0 ? obs_a : obs_b), exp_vec(d));
      end
    end
    vectors++;
    if (obs_a !== 89'd0) begin
      miscompares++;
      $display("FAIL reset_zero: got %h expected 0", obs_a);
    end
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    int i;
    arm = 1'b1; trig_en = 1'b0;
    tick();
    arm = 1'b0;
    i = 0;
    while (state_a != 2'd3 && i < 40) begin
      ALUresult = i; WriteDataMem = $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
          miscompares++;
          $display("FAIL timeout_run dut%0d: got %h expected %h", d, (d == 0 ? obs_a : obs_b), exp_vec(d));
        end
      end
      i++;
    end
    vectors++;
    if ({state_a, timeout_a, triggered_a, valid_a, cyc_a} !== {2'd3, 1'b1, 1'b0, 5'd16, 16'd20}) begin
      miscompares++;
      $display("FAIL timeout_flags: got st=%0d to=%0b tr=%0b vc=%0d cc=%0d expected 3 1 0 16 20",
               state_a, timeout_a, triggered_a, valid_a, cyc_a);
    end
    rd_addr = 4'd0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rd_alu_a !== 32'd4 || rd_wdm_a !== m_rw[0]) begin
      miscompares++;
      $display("FAIL timeout_oldest: got %h/%h expected 4/%h", rd_alu_a, rd_wdm_a, m_rw[0]);
    end
  endtask

  task automatic test_trigger();
    int i;
    arm = 1'b1; trig_en = 1'b1; trig_value = 32'h0000_0007;
    tick();
    arm = 1'b0;
    i = 0;
    while (state_a != 2'd3 && i < 40) begin
      ALUresult = i; WriteDataMem = $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
          miscompares++;
          $display("FAIL trigger_run dut%0d: got %h expected %h", d, (d == 0 ? obs_a : obs_b), exp_vec(d));
        end
      end
      i++;
    end
    vectors++;
    if ({state_a, triggered_a, timeout_a, valid_a} !== {2'd3, 1'b1, 1'b0, 5'd16} || i != 16) begin
      miscompares++;
      $display("FAIL trigger_flags: got st=%0d tr=%0b to=%0b vc=%0d writes=%0d expected 3 1 0 16 16",
               state_a, triggered_a, timeout_a, valid_a, i);
    end
    rd_addr = 4'd7; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rd_alu_a !== 32'd7 || rd_alu_b !== 32'd7) begin
      miscompares++;
      $display("FAIL trigger_read: got %h/%h expected 7/7", rd_alu_a, rd_alu_b);
    end
  endtask

  task automatic test_post0();
    int i;
    arm = 1'b1; trig_en = 1'b1; trig_value = 32'h0000_0003;
    tick();
    arm = 1'b0;
    i = 0;
    while (state_b != 2'd3 && i < 10) begin
      ALUresult = i + 1; WriteDataMem = $urandom;
      tick();
      i++;
    end
    vectors++;
    if (valid_b !== 5'd3 || i != 3 || triggered_b !== 1'b1) begin
      miscompares++;
      $display("FAIL post0_done: got vc=%0d writes=%0d tr=%0b expected 3 3 1", valid_b, i, triggered_b);
    end
    rd_addr = 4'd2; rd_en = 1'b1; ALUresult = 32'd100;
    #1;
    vectors++;
    if (rd_alu_b !== 32'd7) begin
      miscompares++;
      $display("FAIL post0_latency: got %h before edge expected 7", rd_alu_b);
    end
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rd_alu_b !== 32'd3) begin
      miscompares++;
      $display("FAIL post0_read: got %h expected 3", rd_alu_b);
    end
    i = 0;
    while (state_a != 2'd3 && i < 20) begin
      ALUresult = $urandom_range(50, 90); WriteDataMem = $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
          miscompares++;
          $display("FAIL post0_run dut%0d: got %h expected %h", d, (d == 0 ? obs_a : obs_b), exp_vec(d));
        end
      end
      i++;
    end
  endtask

  task automatic test_simultaneous();
    int i;
    arm = 1'b1; trig_en = 1'b1; trig_value = 32'd19;
    tick();
    arm = 1'b0;
    i = 0;
    while (state_b != 2'd3 && i < 40) begin
      ALUresult = i; WriteDataMem = $urandom;
      tick();
      i++;
    end
    vectors++;
    if ({triggered_b, timeout_b, cyc_b} !== {1'b1, 1'b0, 16'd20}) begin
      miscompares++;
      $display("FAIL simul_b: got tr=%0b to=%0b cc=%0d expected 1 0 20", triggered_b, timeout_b, cyc_b);
    end
    i = 0;
    while (state_a != 2'd3 && i < 20) begin
      ALUresult = $urandom; WriteDataMem = $urandom;
      tick();
      i++;
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
        miscompares++;
        $display("FAIL simul_end dut%0d: got %h expected %h", d, (d == 0 ? obs_a : obs_b), exp_vec(d));
      end
    end
  endtask

  task automatic test_reset_post_and_arm();
    int i;
    arm = 1'b1; trig_en = 1'b1; trig_value = 32'd5;
    tick();
    arm = 1'b0;
    i = 0;
    while (state_a != 2'd2 && i < 20) begin
      ALUresult = i; tick(); i++;
    end
    ALUresult = 32'd1000; tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (obs_a !== 89'd0 || obs_b !== 89'd0) begin
      miscompares++;
      $display("FAIL reset_in_post: got %h / %h expected 0", obs_a, obs_b);
    end
    trig_en = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0; ALUresult = $urandom; WriteDataMem = $urandom;
    tick();
    vectors++;
    if (valid_a !== 5'd1 || state_a !== 2'd1) begin
      miscompares++;
      $display("FAIL rearm_count: got vc=%0d st=%0d expected 1 1", valid_a, state_a);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vectors++;
    if (cyc_a !== 16'd2 || state_a !== 2'd1 || valid_a !== 5'd2) begin
      miscompares++;
      $display("FAIL arm_in_pre: got cc=%0d st=%0d vc=%0d expected 2 1 2", cyc_a, state_a, valid_a);
    end
    i = 0;
    while (state_a != 2'd3 && i < 40) begin
      ALUresult = $urandom; WriteDataMem = $urandom; tick(); i++;
    end
    rd_addr = 4'($urandom_range(0, 15)); rd_en = 1'b1; arm = 1'b1;
    tick();
    rd_en = 1'b0; arm = 1'b0;
    vectors++;
    if ({state_a, triggered_a, timeout_a} !== {2'd1, 1'b0, 1'b0} || rd_alu_a !== m_ra[0] || rd_wdm_a !== m_rw[0]) begin
      miscompares++;
      $display("FAIL arm_in_done: got st=%0d tr=%0b to=%0b rd=%h/%h expected 1 0 0 %h/%h",
               state_a, triggered_a, timeout_a, rd_alu_a, rd_wdm_a, m_ra[0], m_rw[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      arm          = ($urandom_range(0, 7) == 0);
      trig_en      = $urandom_range(0, 1);
      ALUresult    = $urandom_range(0, 40);
      WriteDataMem = $urandom;
      if ($urandom_range(0, 9) == 0) trig_value = $urandom_range(0, 40);
      rd_en        = ($urandom_range(0, 2) == 0);
      rd_addr      = 4'($urandom_range(0, 15));
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (((d == 0 ? obs_a : obs_b) & exp_mask(d)) !== (exp_vec(d) & exp_mask(d))) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d: got %h expected %h", d, n, (d == 0 ? obs_a : obs_b), exp_vec(d));
        end
      end
    end
    reset = 1'b0; arm = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_trigger();
    test_post0();
    test_simultaneous();
    test_reset_post_and_arm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
